// File: rtl/stack_controller_pkg.sv
// Shared encodings for the stack engine: request opcodes, FSM states and the
// latched request record. The CPU decoder and the bench import the same package.
package stack_controller_pkg;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;
   localparam logic [1:0] OP_PEEK = 2'b11;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_WRITE = 2'b01;
   localparam logic [1:0] S_READ  = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] data;
   } req_t;

   // Occupancy of a downward-growing stack whose pointer names the next free slot.
   function automatic logic [7:0] stack_fill(input logic [7:0] top, input logic [7:0] sp);
      return top - sp;
   endfunction

endpackage

// File: rtl/stack_controller.sv
// Stack engine in front of the 256x8 data memory: PUSH/POP/PEEK over valid/ready,
// downward-growing SP window, sticky overflow/underflow flags.
module stack_controller
   import stack_controller_pkg::*;
#(
   parameter logic [7:0]  STACK_TOP   = 8'hFF,
   parameter int unsigned STACK_DEPTH = 32'd16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [1:0] req_op,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic [7:0] mem_address,
   output logic [7:0] mem_data_in,
   output logic       mem_write_enable,
   input  logic [7:0] mem_data_out,
   output logic [7:0] sp,
   output logic [7:0] depth,
   output logic       empty,
   output logic       full,
   output logic       err_overflow,
   output logic       err_underflow,
   input  logic       err_clear
);

   localparam logic [7:0] DEPTH_MAX = 8'(STACK_DEPTH);

   logic [1:0] state_q, state_d;
   logic [7:0] sp_q, sp_d;
   req_t       req_q, req_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_err_q, rsp_err_d;
   logic       err_ovf_q, err_ovf_d;
   logic       err_udf_q, err_udf_d;
   logic       set_ovf_s, set_udf_s;
   logic [7:0] depth_s;
   logic       full_s, empty_s;

   assign depth_s = stack_fill(STACK_TOP, sp_q);
   assign full_s  = (depth_s == DEPTH_MAX);
   assign empty_s = (depth_s == 8'd0);

   // Request sequencing, SP update and response capture.
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      req_d      = req_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      set_ovf_s  = 1'b0;
      set_udf_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               req_d.op   = req_op;
               req_d.data = req_data;
               case (req_op)
                  OP_PUSH: begin
                     if (full_s) begin
                        set_ovf_s  = 1'b1;
                        rsp_data_d = 8'h00;
                        rsp_err_d  = 1'b1;
                        state_d    = S_DONE;
                     end else begin
                        state_d = S_WRITE;
                     end
                  end
                  OP_POP, OP_PEEK: begin
                     if (empty_s) begin
                        set_udf_s  = 1'b1;
                        rsp_data_d = 8'h00;
                        rsp_err_d  = 1'b1;
                        state_d    = S_DONE;
                     end else begin
                        state_d = S_READ;
                     end
                  end
                  default: begin
                     rsp_data_d = 8'h00;
                     rsp_err_d  = 1'b0;
                     state_d    = S_DONE;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            sp_d       = sp_q - 8'd1;
            rsp_data_d = 8'h00;
            rsp_err_d  = 1'b0;
            state_d    = S_DONE;
         end
         S_READ: begin
            rsp_data_d = mem_data_out;
            rsp_err_d  = 1'b0;
            if (req_q.op == OP_POP) begin
               sp_d = sp_q + 8'd1;
            end else begin
               sp_d = sp_q;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // A fault detected on the same edge as err_clear keeps its flag set.
   always_comb begin
      err_ovf_d = (err_ovf_q & ~err_clear) | set_ovf_s;
      err_udf_d = (err_udf_q & ~err_clear) | set_udf_s;
   end

   // Memory port: SP-addressed, write strobe only while in WRITE.
   always_comb begin
      mem_address      = sp_q;
      mem_data_in      = 8'h00;
      mem_write_enable = 1'b0;
      case (state_q)
         S_WRITE: begin
            mem_data_in      = req_q.data;
            mem_write_enable = 1'b1;
         end
         S_READ: begin
            mem_address = sp_q + 8'd1;
         end
         default: begin
            mem_address = sp_q;
         end
      endcase
   end

   // State, pointer and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sp_q       <= STACK_TOP;
         req_q      <= '{op: OP_NOP, data: 8'h00};
         rsp_data_q <= 8'h00;
         rsp_err_q  <= 1'b0;
         err_ovf_q  <= 1'b0;
         err_udf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         req_q      <= req_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         err_ovf_q  <= err_ovf_d;
         err_udf_q  <= err_udf_d;
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign rsp_valid     = (state_q == S_DONE);
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;
   assign sp            = sp_q;
   assign depth         = depth_s;
   assign empty         = empty_s;
   assign full          = full_s;
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_udf_q;

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller driving a behavioural 256x8 memory; a queue-based
// stack model is compared against the DUT on every cycle, plus hand-computed spot values.
module tb_stack_controller;
   import stack_controller_pkg::*;

   localparam logic [7:0] TOP   = 8'hFF;
   localparam int         DEPTH = 16;

   logic       clk, rst_n, req_valid, req_ready, rsp_valid, rsp_err;
   logic [1:0] req_op;
   logic [7:0] req_data, rsp_data, mem_address, mem_data_in, mem_data_out, sp, depth;
   logic       mem_write_enable, empty, full, err_overflow, err_underflow, err_clear;

   logic [7:0] mem [256];
   logic       mem_fill;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic [7:0] stk[$];
   bit         ovf, udf;
   bit         exp_ready, exp_valid, exp_err, exp_we;
   logic [7:0] exp_rdata, exp_addr, exp_wdata;

   stack_controller dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
      .mem_data_out(mem_data_out), .sp(sp), .depth(depth), .empty(empty), .full(full),
      .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write on posedge.
   assign mem_data_out = mem[mem_address];
   always @(posedge clk) begin
      if (mem_fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      end else if (mem_write_enable) begin
         mem[mem_address] <= mem_data_in;
      end
   end

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_sp();
      return TOP - 8'(stk.size());
   endfunction

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk8("sp", sp, model_sp());
         chk8("depth", depth, 8'(stk.size()));
         chk1("empty", empty, stk.size() == 0);
         chk1("full", full, stk.size() == DEPTH);
         chk1("req_ready", req_ready, exp_ready);
         chk1("rsp_valid", rsp_valid, exp_valid);
         chk8("rsp_data", rsp_data, exp_rdata);
         chk1("rsp_err", rsp_err, exp_err);
         chk1("mem_we", mem_write_enable, exp_we);
         chk8("mem_addr", mem_address, exp_addr);
         chk8("mem_din", mem_data_in, exp_wdata);
         chk1("err_overflow", err_overflow, ovf);
         chk1("err_underflow", err_underflow, udf);
      end
   end

   task automatic model_reset();
      stk.delete();
      ovf = 1'b0; udf = 1'b0;
      exp_ready = 1'b1; exp_valid = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
      exp_rdata = 8'h00; exp_wdata = 8'h00; exp_addr = TOP;
   endtask

   task automatic finish_rsp(input logic [7:0] d, input bit e);
      exp_valid = 1'b1; exp_rdata = d; exp_err = e; exp_ready = 1'b0;
      exp_we = 1'b0; exp_wdata = 8'h00; exp_addr = model_sp();
      @(posedge clk); #1;
      exp_valid = 1'b0; exp_ready = 1'b1;
   endtask

   task automatic do_op(input logic [1:0] op, input logic [7:0] d, input bit clr, input bit hold);
      int sz;
      logic [7:0] val;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_data = d; err_clear = clr;
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      err_clear = 1'b0;
      req_data  = ~d;
      sz = stk.size();
      if (clr) begin ovf = 1'b0; udf = 1'b0; end
      exp_ready = 1'b0;
      case (op)
         OP_PUSH: begin
            if (sz == DEPTH) begin
               ovf = 1'b1;
               finish_rsp(8'h00, 1'b1);
            end else begin
               exp_we = 1'b1; exp_wdata = d; exp_addr = model_sp();
               @(posedge clk); #1;
               stk.push_back(d);
               finish_rsp(8'h00, 1'b0);
            end
         end
         OP_POP, OP_PEEK: begin
            if (sz == 0) begin
               udf = 1'b1;
               finish_rsp(8'h00, 1'b1);
            end else begin
               exp_addr = model_sp() + 8'd1;
               @(posedge clk); #1;
               val = stk[$];
               if (op == OP_POP) void'(stk.pop_back());
               finish_rsp(val, 1'b0);
            end
         end
         default: finish_rsp(8'h00, 1'b0);
      endcase
   endtask

   task automatic clear_only();
      @(negedge clk); err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0; ovf = 1'b0; udf = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      clk = 1'b0; rst_n = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_data = 8'h00;
      err_clear = 1'b0; mem_fill = 1'b1;
      model_reset();
      #3 rst_n = 1'b0;
      #1;
      chk8("rst_sp", sp, 8'hFF);
      chk8("rst_depth", depth, 8'h00);
      chk1("rst_empty", empty, 1'b1);
      chk1("rst_full", full, 1'b0);
      chk1("rst_we", mem_write_enable, 1'b0);
      chk1("rst_valid", rsp_valid, 1'b0);
      chk1("rst_ovf", err_overflow, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_fill = 1'b0; rst_n = 1'b1; chk_en = 1'b1;
      #1 chk1("rst_ready", req_ready, 1'b1);

      do_op(OP_PUSH, 8'hA5, 1'b0, 1'b0);
      do_op(OP_PUSH, 8'h3C, 1'b0, 1'b0);
      chk8("push_mem_ff", mem[8'hFF], 8'hA5);
      chk8("push_mem_fe", mem[8'hFE], 8'h3C);
      chk8("push_sp", sp, 8'hFD);
      chk8("push_depth", depth, 8'h02);

      do_op(OP_PEEK, 8'h00, 1'b0, 1'b0);
      chk8("peek_data", rsp_data, 8'h3C);
      chk8("peek_sp", sp, 8'hFD);
      do_op(OP_POP, 8'h00, 1'b0, 1'b0);
      chk8("pop1_data", rsp_data, 8'h3C);
      chk8("pop1_sp", sp, 8'hFE);
      do_op(OP_POP, 8'h00, 1'b0, 1'b0);
      chk8("pop2_data", rsp_data, 8'hA5);
      chk1("pop2_empty", empty, 1'b1);

      do_op(OP_NOP, 8'h77, 1'b0, 1'b0);
      chk8("nop_data", rsp_data, 8'h00);

      for (int i = 0; i < 16; i++) do_op(OP_PUSH, 8'(i), 1'b0, 1'b0);
      chk1("fill_full", full, 1'b1);
      chk8("fill_sp", sp, 8'hEF);
      chk8("fill_mem_f0", mem[8'hF0], 8'h0F);
      do_op(OP_PUSH, 8'h99, 1'b0, 1'b0);
      chk1("ovf_err", rsp_err, 1'b1);
      chk8("ovf_mem_ef", mem[8'hEF], 8'hB5);
      chk1("ovf_flag", err_overflow, 1'b1);

      for (int i = 0; i < 16; i++) do_op(OP_POP, 8'h00, 1'b0, 1'b0);
      chk8("drain_last", rsp_data, 8'h00);
      do_op(OP_POP, 8'h00, 1'b0, 1'b0);
      chk1("udf_err", rsp_err, 1'b1);
      chk8("udf_data", rsp_data, 8'h00);
      chk1("udf_flag", err_underflow, 1'b1);
      chk8("udf_sp", sp, 8'hFF);
      clear_only();
      chk1("clr_ovf", err_overflow, 1'b0);
      chk1("clr_udf", err_underflow, 1'b0);

      do_op(OP_PEEK, 8'h00, 1'b1, 1'b0);
      chk1("set_wins", err_underflow, 1'b1);

      do_op(OP_PUSH, 8'h11, 1'b0, 1'b1);
      do_op(OP_POP,  8'h00, 1'b0, 1'b1);
      do_op(OP_PUSH, 8'h22, 1'b0, 1'b1);
      do_op(OP_POP,  8'h00, 1'b0, 1'b1);
      do_op(OP_PUSH, 8'h33, 1'b0, 1'b1);
      do_op(OP_PUSH, 8'h44, 1'b0, 1'b1);
      do_op(OP_POP,  8'h00, 1'b0, 1'b1);
      chk8("hold_pop", rsp_data, 8'h44);
      do_op(OP_POP,  8'h00, 1'b0, 1'b0);
      chk8("hold_mem_fe", mem[8'hFE], 8'h44);

      do_op(OP_PUSH, 8'h55, 1'b0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_PUSH; req_data = 8'hE1;
      @(posedge clk); #1;
      req_valid = 1'b0; chk_en = 1'b0;
      chk1("mw_we_pre", mem_write_enable, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk1("mw_we", mem_write_enable, 1'b0);
      chk8("mw_sp", sp, 8'hFF);
      chk1("mw_empty", empty, 1'b1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1; chk_en = 1'b1;
      do_op(OP_PUSH, 8'h77, 1'b0, 1'b0);
      chk8("post_rst_mem", mem[8'hFF], 8'h77);

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
